// File: rtl/tdc_readout_pkg.sv
// tdc_readout_pkg: shared types and defaults for the readout sequencer.
// Holds the FSM state encoding, the idle address and parameter defaults.
package tdc_readout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Address 31 is decoded as "no byte selected".
    localparam logic [4:0] IDLE_ADDR = 5'd31;

    localparam int DEF_SETTLE_CYCLES = 2;
    localparam int DEF_LAST_ADDR     = 23;
    localparam int DEF_SKIP_ADDR     = 6;

    // Next readout address, hopping over the unpopulated slot.
    function automatic logic [4:0] step_addr(
        input logic [4:0] a,
        input logic [4:0] skip
    );
        logic [4:0] n;
        n = a + 5'd1;
        return (n == skip) ? n + 5'd1 : n;
    endfunction

endpackage

// File: rtl/readout_seq_if.sv
// readout_seq_if: control, data and handshake bundle of the readout sequencer.
// master: sequencer side (drives addr/byte_out/byte_valid/last/busy/done);
// slave: controller and readout-bus side (drives start/abort/data_in/out_ready).
interface readout_seq_if;

    logic       start;
    logic       abort;
    logic [7:0] data_in;
    logic       out_ready;
    logic [4:0] addr;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       last;
    logic       busy;
    logic       done;

    modport master (
        input  start,
        input  abort,
        input  data_in,
        input  out_ready,
        output addr,
        output byte_out,
        output byte_valid,
        output last,
        output busy,
        output done
    );

    modport slave (
        output start,
        output abort,
        output data_in,
        output out_ready,
        input  addr,
        input  byte_out,
        input  byte_valid,
        input  last,
        input  busy,
        input  done
    );

endinterface

// File: rtl/readout_seq.sv
// readout_seq: walks the byte-select address over one readout frame, lets the
// shared bus settle, captures each byte and offers it on a valid/ready output.
// Ports: clk, reset (sync, active high), bus (readout_seq_if.master):
//   start/abort/data_in/out_ready in; addr/byte_out/byte_valid/last/busy/done out.
module readout_seq
    import tdc_readout_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int LAST_ADDR     = DEF_LAST_ADDR,
    parameter int SKIP_ADDR     = DEF_SKIP_ADDR
) (
    input  logic          clk,
    input  logic          reset,
    readout_seq_if.master bus
);

    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [4:0] LAST_A     = 5'(LAST_ADDR);
    localparam logic [4:0] SKIP_A     = 5'(SKIP_ADDR);
    // A frame normally opens at address 0 unless that slot is the skipped one.
    localparam logic [4:0] FIRST_A    = (SKIP_A == 5'd0) ? 5'd1 : 5'd0;

    state_e     state_q, state_d;
    logic [4:0] addr_q,  addr_d;
    logic [7:0] byte_q,  byte_d;
    logic [3:0] cnt_q,   cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= IDLE_ADDR;
            byte_q  <= 8'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        byte_d  = byte_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                // abort in IDLE masks a simultaneous start
                if (bus.start && !bus.abort) begin
                    state_d = ST_SETTLE;
                    addr_d  = FIRST_A;
                    cnt_d   = CNT_RELOAD;
                end
            end
            ST_SETTLE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    addr_d  = IDLE_ADDR;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_PRESENT;
                    byte_d  = bus.data_in;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_PRESENT: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    addr_d  = IDLE_ADDR;
                    cnt_d   = 4'd0;
                end else if (bus.out_ready) begin
                    if (addr_q == LAST_A) begin
                        state_d = ST_DONE;
                        addr_d  = IDLE_ADDR;
                    end else begin
                        state_d = ST_SETTLE;
                        addr_d  = step_addr(addr_q, SKIP_A);
                        cnt_d   = CNT_RELOAD;
                    end
                end
            end
            ST_DONE: begin
                // done pulses for exactly this one cycle; abort is ignored
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = IDLE_ADDR;
            end
        endcase
    end

    assign bus.addr       = addr_q;
    assign bus.byte_out   = byte_q;
    assign bus.byte_valid = (state_q == ST_PRESENT);
    assign bus.last       = (state_q == ST_PRESENT) && (addr_q == LAST_A);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_readout_seq.sv
// tb_readout_seq: vector table, directed corner sequences and a randomized
// run against a timing-level reference model of the readout sequencer.
module tb_readout_seq;

    localparam int S    = 2;
    localparam int LAST = 23;
    localparam int SKIP = 6;

    typedef struct {
        logic [3:0] in;  // {reset, start, abort, out_ready}
        logic [3:0] ex;  // {byte_valid, busy, done, last}
        logic [4:0] a;   // expected addr (byte_out == a when valid)
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem [32];
    int         alist [$];
    vec_t       tv [13];

    int n, cyc, last_cyc, dn, nb, ev, idx, due, done_at, ea;
    bit got, inf, vprev, r_rst, r_st, r_ab, r_rdy, ev_valid;

    readout_seq_if bus ();
    readout_seq_if bus2 ();

    readout_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    readout_seq #(
        .SETTLE_CYCLES (1),
        .LAST_ADDR     (5),
        .SKIP_ADDR     (6)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    // Select decoder model: the addressed source drives the shared bus.
    assign bus.data_in  = mem[bus.addr];
    assign bus2.data_in = mem[bus2.addr];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (bus.done) seen = 1'b1;
            else tick();
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    initial begin
        idle_inputs();
        bus2.start     = 1'b0;
        bus2.abort     = 1'b0;
        bus2.out_ready = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = 8'(i);
        for (int a = 0; a <= LAST; a++) if (a != SKIP) alist.push_back(a);

        // ---------------- vector table ----------------
        tv[0]  = '{4'b1000, 4'b0000, 5'd31};
        tv[1]  = '{4'b0110, 4'b0000, 5'd31};
        tv[2]  = '{4'b0100, 4'b0100, 5'd0};
        tv[3]  = '{4'b0000, 4'b0100, 5'd0};
        tv[4]  = '{4'b0000, 4'b1100, 5'd0};
        tv[5]  = '{4'b0100, 4'b1100, 5'd0};
        tv[6]  = '{4'b0001, 4'b0100, 5'd1};
        tv[7]  = '{4'b0001, 4'b0100, 5'd1};
        tv[8]  = '{4'b0001, 4'b1100, 5'd1};
        tv[9]  = '{4'b0011, 4'b0000, 5'd31};
        tv[10] = '{4'b0000, 4'b0000, 5'd31};
        tv[11] = '{4'b0100, 4'b0100, 5'd0};
        tv[12] = '{4'b1101, 4'b0000, 5'd31};
        for (int i = 0; i < 13; i++) begin
            reset         = tv[i].in[3];
            bus.start     = tv[i].in[2];
            bus.abort     = tv[i].in[1];
            bus.out_ready = tv[i].in[0];
            tick();
            chk($sformatf("t%0d_addr", i), 32'(bus.addr), 32'(tv[i].a));
            chk($sformatf("t%0d_valid", i), 32'(bus.byte_valid), 32'(tv[i].ex[3]));
            chk($sformatf("t%0d_busy", i), 32'(bus.busy), 32'(tv[i].ex[2]));
            chk($sformatf("t%0d_done", i), 32'(bus.done), 32'(tv[i].ex[1]));
            chk($sformatf("t%0d_last", i), 32'(bus.last), 32'(tv[i].ex[0]));
            if (tv[i].ex[3])
                chk($sformatf("t%0d_byte", i), 32'(bus.byte_out), 32'(tv[i].a));
            if (tv[i].in[3])
                chk($sformatf("t%0d_rbyte", i), 32'(bus.byte_out), 32'd0);
        end

        // ---------------- full frame, ready high ----------------
        do_reset();
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0; cyc = 1; last_cyc = -1; got = 1'b0;
        while (cyc < 120 && !got) begin
            if (bus.byte_valid) begin
                ea = (n < alist.size()) ? alist[n] : 99;
                chk("a_vcyc", 32'(cyc), 32'(3 * (n + 1)));
                chk("a_addr", 32'(bus.addr), 32'(ea));
                chk("a_byte", 32'(bus.byte_out), 32'(ea));
                chk("a_last", 32'(bus.last), 32'(n == 22));
                last_cyc = cyc;
                n++;
            end
            if (bus.done) begin
                got = 1'b1;
                chk("a_donecyc", 32'(cyc), 32'(last_cyc + 1));
            end else begin
                tick();
                cyc++;
            end
        end
        chk("a_count", 32'(n), 32'd23);
        chk("a_done", 32'(got), 32'd1);
        tick();
        chk("a_idle_busy", 32'(bus.busy), 32'd0);
        chk("a_idle_addr", 32'(bus.addr), 32'd31);

        // ---------------- stall at addr 3 ----------------
        do_reset();
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (bus.byte_valid && bus.addr == 5'd3) got = 1'b1;
            else tick();
        end
        chk("b_reach3", 32'(got), 32'd1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("b_hold_v", 32'(bus.byte_valid), 32'd1);
            chk("b_hold_a", 32'(bus.addr), 32'd3);
            chk("b_hold_d", 32'(bus.byte_out), 32'd3);
            tick();
        end
        chk("b_still_v", 32'(bus.byte_valid), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("b_next_a", 32'(bus.addr), 32'd4);
        chk("b_next_v", 32'(bus.byte_valid), 32'd0);
        wait_done("b_done", 100);

        // ---------------- start while busy ignored ----------------
        do_reset();
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        dn = 0; nb = 0;
        for (int i = 0; i < 150; i++) begin
            if (bus.done) dn++;
            if (bus.byte_valid) nb++;
            bus.start = bus.busy && (bus.addr == 5'd2 || bus.addr == 5'd12);
            tick();
        end
        bus.start = 1'b0;
        chk("c_dones", 32'(dn), 32'd1);
        chk("c_bytes", 32'(nb), 32'd23);
        chk("c_idle", 32'(bus.busy), 32'd0);

        // ---------------- reset in SETTLE at addr 15 ----------------
        do_reset();
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            if (bus.busy && !bus.byte_valid && bus.addr == 5'd15) got = 1'b1;
            else tick();
        end
        chk("d_reach15", 32'(got), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("d_addr", 32'(bus.addr), 32'd31);
        chk("d_byte", 32'(bus.byte_out), 32'd0);
        chk("d_valid", 32'(bus.byte_valid), 32'd0);
        chk("d_last", 32'(bus.last), 32'd0);
        chk("d_busy", 32'(bus.busy), 32'd0);
        chk("d_done", 32'(bus.done), 32'd0);
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) dn++;
            tick();
        end
        chk("d_nodone", 32'(dn), 32'd0);

        // ---------------- abort in PRESENT at addr 10 ----------------
        do_reset();
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (bus.byte_valid && bus.addr == 5'd10) got = 1'b1;
            else tick();
        end
        chk("f_reach10", 32'(got), 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("f_addr", 32'(bus.addr), 32'd31);
        chk("f_valid", 32'(bus.byte_valid), 32'd0);
        chk("f_busy", 32'(bus.busy), 32'd0);
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.done) dn++;
            tick();
        end
        chk("f_nodone", 32'(dn), 32'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (bus.byte_valid) got = 1'b1;
            else tick();
        end
        chk("f_restart_v", 32'(got), 32'd1);
        chk("f_restart_a", 32'(bus.addr), 32'd0);

        // ---------------- short frame, SETTLE_CYCLES=1 LAST_ADDR=5 -------
        do_reset();
        bus2.out_ready = 1'b1;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        n = 0; cyc = 1; last_cyc = -1; got = 1'b0;
        while (cyc < 40 && !got) begin
            if (bus2.byte_valid) begin
                chk("e_vcyc", 32'(cyc), 32'(2 * (n + 1)));
                chk("e_addr", 32'(bus2.addr), 32'(n));
                chk("e_byte", 32'(bus2.byte_out), 32'(n));
                chk("e_last", 32'(bus2.last), 32'(n == 5));
                last_cyc = cyc;
                n++;
            end
            if (bus2.done) begin
                got = 1'b1;
                chk("e_donecyc", 32'(cyc), 32'(last_cyc + 1));
            end else begin
                tick();
                cyc++;
            end
        end
        chk("e_count", 32'(n), 32'd6);
        chk("e_done", 32'(got), 32'd1);
        bus2.out_ready = 1'b0;

        // ---------------- randomized run vs timing model ----------------
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        do_reset();
        ev = 0; inf = 1'b0; idx = 0; due = 0; done_at = -10;
        for (int k = 0; k < 3000; k++) begin
            r_rst = ($urandom_range(0, 299) == 0);
            r_st  = ($urandom_range(0, 5) == 0);
            r_ab  = ($urandom_range(0, 39) == 0);
            r_rdy = ($urandom_range(0, 1) == 1);
            reset         = r_rst;
            bus.start     = r_st;
            bus.abort     = r_ab;
            bus.out_ready = r_rdy;
            // a byte is on offer from edge 'due' until it is accepted
            vprev = inf && (ev >= due);
            tick();
            ev++;
            if (r_rst) begin
                inf = 1'b0;
                done_at = -10;
            end else if (inf && r_ab) begin
                inf = 1'b0;
            end else if (vprev && r_rdy) begin
                if (idx == alist.size() - 1) begin
                    inf = 1'b0;
                    done_at = ev;
                end else begin
                    idx++;
                    due = ev + S;
                end
            end else if (!inf && done_at != ev - 1 && r_st && !r_ab) begin
                inf = 1'b1;
                idx = 0;
                due = ev + S;
            end
            ev_valid = inf && (ev >= due);
            ea = inf ? alist[idx] : 31;
            chk("r_valid", 32'(bus.byte_valid), 32'(ev_valid));
            chk("r_addr", 32'(bus.addr), 32'(ea));
            chk("r_busy", 32'(bus.busy), 32'(inf || done_at == ev));
            chk("r_done", 32'(bus.done), 32'(done_at == ev));
            chk("r_last", 32'(bus.last),
                32'(ev_valid && idx == alist.size() - 1));
            if (ev_valid)
                chk("r_byte", 32'(bus.byte_out), 32'(mem[ea]));
            if (r_rst)
                chk("r_rbyte", 32'(bus.byte_out), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
